// File: rtl/vmicro16_mem_master.sv
// Burst memory master: turns one read/write command into a run of single-word
// accesses on a synchronous-read memory port. Read data comes straight from
// the memory one cycle after each address. Write words are taken one per
// handshake and may stall for any length of time.
module vmicro16_mem_master #(
  parameter int unsigned MEM_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  // command channel
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [MEM_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0] req_len,
  // write data channel
  input  logic                 wd_valid,
  output logic                 wd_ready,
  input  logic [MEM_WIDTH-1:0] wd_data,
  // read data channel (no backpressure)
  output logic                 rd_valid,
  output logic [MEM_WIDTH-1:0] rd_data,
  output logic                 done,
  // memory port
  output logic [MEM_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0] mem_in,
  output logic                 mem_we,
  input  logic [MEM_WIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [MEM_WIDTH-1:0] AddrOne = MEM_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] CntOne  = LEN_WIDTH'(1);

  state_e                 r_state;
  logic [MEM_WIDTH-1:0]   r_cur_addr;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic                   r_rd_pend;

  state_e                 w_state_next;
  logic [MEM_WIDTH-1:0]   w_cur_addr_next;
  logic [LEN_WIDTH-1:0]   w_cnt_next;
  logic                   w_rd_pend_next;
  logic                   w_last;
  logic                   w_wr_fire;

  // cnt counts remaining words minus one, so zero marks the final beat
  assign w_last    = (r_cnt == '0);
  assign w_wr_fire = (r_state == StWrite) && wd_valid;

  // State register; async reset aborts any burst in progress immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cur_addr <= '0;
      r_cnt      <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cur_addr <= w_cur_addr_next;
      r_cnt      <= w_cnt_next;
      r_rd_pend  <= w_rd_pend_next;
    end
  end

  // Next-state logic: one memory beat per READ cycle, one per accepted write word
  always_comb begin
    w_state_next    = r_state;
    w_cur_addr_next = r_cur_addr;
    w_cnt_next      = r_cnt;
    // each READ beat returns data exactly one cycle later
    w_rd_pend_next  = (r_state == StRead);
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_cur_addr_next = req_addr;
          w_cnt_next      = req_len;
          w_state_next    = req_we ? StWrite : StRead;
        end
      end
      StRead: begin
        w_cur_addr_next = r_cur_addr + AddrOne;
        w_cnt_next      = r_cnt - CntOne;
        if (w_last) begin
          w_state_next = StDrain;
        end
      end
      StWrite: begin
        if (wd_valid) begin
          w_cur_addr_next = r_cur_addr + AddrOne;
          w_cnt_next      = r_cnt - CntOne;
          if (w_last) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output decode; the address always follows the running pointer
  always_comb begin
    req_ready = (r_state == StIdle);
    wd_ready  = (r_state == StWrite);
    done      = (r_state == StDrain);
    mem_we    = w_wr_fire;
    mem_addr  = r_cur_addr;
    mem_in    = wd_data;
    rd_valid  = r_rd_pend;
    rd_data   = mem_out;
  end

endmodule

// File: tb/tb_vmicro16_mem_master.sv
// Self-checking bench for vmicro16_mem_master: a behavioural memory, a
// reference memory map, and a scoreboard fed by the stimulus and drained by a
// monitor that watches write strobes, read data and done pulses.
module tb_vmicro16_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [3:0]  req_len;
  logic        wd_valid;
  logic        wd_ready;
  logic [15:0] wd_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        done;
  logic [15:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_we;
  logic [15:0] mem_out = 16'h0;

  vmicro16_mem_master #(
    .MEM_WIDTH(16),
    .LEN_WIDTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_we   (mem_we),
    .mem_out  (mem_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; untouched words read back as their own address
  logic [15:0] mem [65536];
  logic        mem_written [65536];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]         <= mem_in;
      mem_written[mem_addr] <= 1'b1;
    end
    mem_out <= mem_written[mem_addr] ? mem[mem_addr] : mem_addr;
  end

  // Reference model and scoreboard
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_rd [$];
  logic [31:0] exp_wr [$];
  int          exp_done;
  int          n_cmp;
  int          n_fail;
  logic [15:0] wbuf [16];
  int          stall_buf [16];
  logic [31:0] mon_e;

  function automatic logic [15:0] ref_get(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a;
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expected item
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wr_unexpected: got write addr %h, required none (t=%0t)", mem_addr, $time);
      end else begin
        mon_e = exp_wr.pop_front();
        chk_w("wr_addr", mem_addr, mon_e[31:16]);
        chk_w("wr_data", mem_in, mon_e[15:0]);
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_data %h, required none (t=%0t)", rd_data, $time);
      end else begin
        chk_w("rd_data", rd_data, exp_rd.pop_front());
      end
    end
    if (done) begin
      n_cmp++;
      if (exp_done == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got done=1 required 0 (t=%0t)", $time);
      end else begin
        exp_done--;
      end
    end
  end

  // Write burst; abort_at >= 0 asserts reset while that word is presented
  task automatic do_write(input logic [15:0] addr, input int len, input int abort_at);
    logic [15:0] a;
    bit          aborted;
    aborted = 1'b0;
    chk_b("w_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_len   = 4'(len);
    exp_done++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    for (int k = 0; k <= len; k++) begin
      a = addr + 16'(k);
      for (int s = 0; s < stall_buf[k]; s++) begin
        wd_valid = 1'b0;
        wd_data  = 16'($urandom);
        @(negedge clk);
        chk_b("stall_mem_we", mem_we, 1'b0);
        chk_w("stall_mem_addr", mem_addr, a);
        chk_b("stall_wd_ready", wd_ready, 1'b1);
        @(posedge clk); #1;
      end
      wd_valid = 1'b1;
      wd_data  = wbuf[k];
      if (k == abort_at) begin
        #1;
        reset = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        exp_done = 0;
        #1;
        chk_b("abort_mem_we", mem_we, 1'b0);
        chk_b("abort_done", done, 1'b0);
        chk_b("abort_req_ready", req_ready, 1'b1);
        chk_b("abort_wd_ready", wd_ready, 1'b0);
        chk_w("abort_mem_addr", mem_addr, 16'h0000);
        aborted = 1'b1;
        break;
      end
      exp_wr.push_back({a, wbuf[k]});
      ref_mem[a] = wbuf[k];
      @(negedge clk);
      chk_b("w_mem_we", mem_we, 1'b1);
      @(posedge clk); #1;
    end
    wd_valid = 1'b0;
    if (aborted) begin
      repeat (2) begin
        @(negedge clk);
        chk_b("abort_no_done", done, 1'b0);
        chk_b("abort_no_we", mem_we, 1'b0);
      end
      @(posedge clk); #3;
      reset = 1'b1;
    end else begin
      @(negedge clk);
      chk_b("w_done", done, 1'b1);
      chk_b("w_drain_we", mem_we, 1'b0);
      @(negedge clk);
      chk_b("w_idle_ready", req_ready, 1'b1);
    end
  endtask

  // Issue a read command (DUT must be idle); garbage on the write channel
  task automatic start_read(input logic [15:0] addr, input int len);
    chk_b("r_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    req_len   = 4'(len);
    wd_valid  = 1'($urandom_range(0, 1));
    wd_data   = 16'($urandom);
    for (int i = 0; i <= len; i++) exp_rd.push_back(ref_get(addr + 16'(i)));
    exp_done++;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycle-accurate shape of a read burst: len+1 issue cycles then one drain
  task automatic check_read(input logic [15:0] addr, input int len);
    for (int c = 1; c <= len + 2; c++) begin
      @(negedge clk);
      if (c <= len + 1) chk_w("r_mem_addr", mem_addr, addr + 16'(c - 1));
      chk_b("r_rd_valid", rd_valid, c >= 2);
      chk_b("r_done", done, c == len + 2);
      chk_b("r_mem_we", mem_we, 1'b0);
    end
    wd_valid = 1'b0;
    @(negedge clk);
    chk_b("r_idle_ready", req_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] ra;
    int          rl;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0;
    req_len   = 4'h0;
    wd_valid  = 1'b0;
    wd_data   = 16'h0;
    exp_done  = 0;
    n_cmp     = 0;
    n_fail    = 0;
    for (int k = 0; k < 16; k++) stall_buf[k] = 0;

    // Reset state, including requests presented while reset is held
    #3 reset = 1'b0;
    @(negedge clk);
    chk_b("rst_req_ready", req_ready, 1'b1);
    chk_b("rst_wd_ready", wd_ready, 1'b0);
    chk_b("rst_rd_valid", rd_valid, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_mem_we", mem_we, 1'b0);
    chk_w("rst_mem_addr", mem_addr, 16'h0000);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0055;
    wd_valid  = 1'b1;
    @(negedge clk);
    chk_b("rst_hold_req_ready", req_ready, 1'b1);
    chk_b("rst_hold_wd_ready", wd_ready, 1'b0);
    chk_b("rst_hold_mem_we", mem_we, 1'b0);
    chk_w("rst_hold_mem_addr", mem_addr, 16'h0000);
    req_valid = 1'b0;
    wd_valid  = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);

    // Single word: store 0x1234 at 0x0020, read it back
    wbuf[0] = 16'h1234;
    do_write(16'h0020, 0, -1);
    start_read(16'h0020, 0);
    check_read(16'h0020, 0);

    // Three-word write with a two-cycle stall before the last word, then read back
    wbuf[0] = 16'h00A1;
    wbuf[1] = 16'h00A2;
    wbuf[2] = 16'h00A3;
    stall_buf[2] = 2;
    do_write(16'h0010, 2, -1);
    stall_buf[2] = 0;
    start_read(16'h0010, 2);
    check_read(16'h0010, 2);

    // Address wrap
    start_read(16'hFFFF, 1);
    check_read(16'hFFFF, 1);

    // Full-length burst
    start_read(16'h0100, 15);
    check_read(16'h0100, 15);

    // Request held high during a 16-word burst with a different address
    start_read(16'h0200, 15);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0300;
    req_len   = 4'd2;
    check_read(16'h0200, 15);
    start_read(16'h0300, 2);
    check_read(16'h0300, 2);

    // Reset during the second word of a four-word write, then read-back
    for (int k = 0; k < 4; k++) wbuf[k] = 16'($urandom);
    do_write(16'h0400, 3, 1);
    start_read(16'h0400, 3);
    check_read(16'h0400, 3);

    // Random mix over two overlapping address windows (one straddles the wrap)
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) ra = 16'hFFF8 + 16'($urandom_range(0, 15));
      else                           ra = 16'h0400 + 16'($urandom_range(0, 31));
      rl = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin
          wbuf[k]      = 16'($urandom);
          stall_buf[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
        do_write(ra, rl, -1);
      end else begin
        start_read(ra, rl);
        check_read(ra, rl);
      end
    end

    repeat (3) @(negedge clk);
    chk_w("end_rd_queue", 16'(exp_rd.size()), 16'h0);
    chk_w("end_wr_queue", 16'(exp_wr.size()), 16'h0);
    chk_w("end_done_count", 16'(exp_done), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time limit so the bench can never hang
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vmicro16_mem_master.md
VMICRO16_MEM_MASTER -- requirements
Module: vmicro16_mem_master

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MEM_WIDTH, default 16, giving the width of address and data.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 4, giving the width of the burst-length field.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port req_valid, input, 1, command request.
REQ-006 The block SHALL have port req_ready, output, 1, command accepted when high together with req_valid.
REQ-007 The block SHALL have port req_we, input, 1, command direction: 1 = write burst, 0 = read burst.
REQ-008 The block SHALL have port req_addr, input, MEM_WIDTH, start word address.
REQ-009 The block SHALL have port req_len, input, LEN_WIDTH, burst length in words minus 1.
REQ-010 The block SHALL have port wd_valid, input, 1, write word available.
REQ-011 The block SHALL have port wd_ready, output, 1, write word accepted when high together with wd_valid.
REQ-012 The block SHALL have port wd_data, input, MEM_WIDTH, write word.
REQ-013 The block SHALL have port rd_valid, output, 1, read word present; there is no backpressure.
REQ-014 The block SHALL have port rd_data, output, MEM_WIDTH, read word.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse marking the end of a burst.
REQ-016 The block SHALL have ports mem_addr (output, MEM_WIDTH), mem_in (output, MEM_WIDTH) and mem_we (output, 1), which drive the memory.
REQ-017 The block SHALL have port mem_out, input, MEM_WIDTH, memory read data, valid one cycle after an address is presented with mem_we=0.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE and DRAIN, and SHALL hold registers cur_addr, cnt and rd_pend.
REQ-019 req_ready SHALL be 1 only in IDLE; req_valid SHALL be ignored in all other states.
REQ-020 In IDLE with req_valid=1 at a clock edge, the block SHALL load cur_addr<=req_addr and cnt<=req_len, and SHALL move to WRITE if req_we=1, else to READ.
REQ-021 In READ, every cycle the block SHALL drive mem_addr=cur_addr and mem_we=0, increment cur_addr, decrement cnt and set rd_pend<=1.
REQ-022 In READ, the block SHALL move to DRAIN in the cycle it issues with cnt==0.
REQ-023 rd_valid SHALL equal the registered rd_pend, and rd_data SHALL equal mem_out (pass-through); each read word therefore appears exactly 1 cycle after its address is issued.
REQ-024 A burst of req_len+1 words SHALL occupy req_len+1 consecutive READ cycles plus 1 DRAIN cycle, with no bubbles.
REQ-025 In WRITE, wd_ready SHALL be 1.
REQ-026 In WRITE with wd_valid=1, the block SHALL drive mem_we=1, mem_addr=cur_addr and mem_in=wd_data, increment cur_addr and decrement cnt; if cnt==0 it SHALL move to DRAIN.
REQ-027 In WRITE with wd_valid=0, the block SHALL drive mem_we=0, SHALL hold mem_addr=cur_addr, and SHALL leave cnt unchanged (stall of any length).
REQ-028 DRAIN SHALL last exactly 1 cycle and SHALL assert done=1; rd_valid SHALL be 1 in DRAIN only after a read burst; the next state SHALL be IDLE.
REQ-029 mem_we SHALL be 1 only in WRITE with wd_valid=1; it SHALL never be 1 in IDLE, READ or DRAIN.
REQ-030 mem_in SHALL be wd_data in all states.
REQ-031 In IDLE and DRAIN, mem_addr SHALL be cur_addr.
REQ-032 cur_addr SHALL increment modulo 2^MEM_WIDTH, so 0xFFFF+1 = 0x0000 with no error or flag.
REQ-033 req_len=0 SHALL produce a single-word access; req_len=2^LEN_WIDTH-1 SHALL produce a 16-word burst.
REQ-034 wd_valid and wd_data SHALL be ignored outside WRITE.
REQ-035 A new request SHALL be acceptable in the IDLE cycle immediately after DRAIN; the block SHALL therefore issue at most one burst every req_len+3 cycles.

Reset
REQ-036 While reset=0 the block SHALL force state=IDLE, cur_addr=0, cnt=0 and rd_pend=0, taking effect asynchronously.
REQ-037 During reset the outputs SHALL be req_ready=1, wd_ready=0, rd_valid=0, done=0, mem_we=0 and mem_addr=0.
REQ-038 Reset asserted mid-burst SHALL abort the burst immediately: mem_we SHALL drop in the same cycle, no done SHALL be produced, and the remaining words SHALL be discarded.
REQ-039 After reset deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-040 The bench SHALL check a single read: memory[0x0020]=0x1234, request read addr 0x0020 len 0 accepted at edge 0 -> mem_addr=0x0020 in cycle 1, rd_valid=1 with rd_data=0x1234 and done=1 in cycle 2, req_ready=1 in cycle 3.
REQ-041 The bench SHALL check a write burst with stall: write addr 0x0010 len 2, data 0xA1, 0xA2, 0xA3 with wd_valid low for 2 cycles between 0xA2 and 0xA3 -> exactly 3 mem_we pulses to 0x0010, 0x0011 and 0x0012; done 1 cycle after the third write; a read-back burst returns 0xA1, 0xA2, 0xA3 on consecutive cycles.
REQ-042 The bench SHALL check address wrap: read addr 0xFFFF len 1 -> mem_addr sequence 0xFFFF then 0x0000, and 2 rd_valid cycles.
REQ-043 The bench SHALL check a request while busy: req_valid held high during a 16-word read with changed req_addr -> ignored; the second command is accepted only in the IDLE cycle after done.
REQ-044 The bench SHALL check reset mid-operation: reset=0 asserted during the 2nd word of a 4-word write -> mem_we=0 at once, no done, memory words 3 and 4 unchanged, and a new read is accepted on the first edge after release.
REQ-045 The bench SHALL check a full-length burst: read len 15 from 0x0100 -> 16 back-to-back rd_valid cycles carrying words 0x0100 to 0x010F in order, with done coincident with the 16th word.
